// File: rtl/fifo_uart_pkg.sv
// Shared state encoding and default baud constants for the FIFO-fed UART transmitter.
package fifo_uart_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StReq    = 3'd1,
        StLoad   = 3'd2,
        StStart  = 3'd3,
        StData   = 3'd4,
        StParity = 3'd5,
        StStop   = 3'd6
    } tx_state_e;

    localparam int unsigned ClkDivDefault  = 868;
    localparam int unsigned DivBitsDefault = 10;

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running baud divider: counts 0..CLK_DIV-1, ticks on the last count, synchronous clear.
module uart_baud_tick
    import fifo_uart_pkg::*;
#(
    parameter int unsigned CLK_DIV  = ClkDivDefault,
    parameter int unsigned DIV_BITS = DivBitsDefault
) (
    input  logic i_clk,
    input  logic i_rest,
    input  logic i_clr,
    output logic o_tick
);

    localparam logic [DIV_BITS-1:0] CntMax = DIV_BITS'(CLK_DIV - 1);

    logic [DIV_BITS-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr || (cnt_q == CntMax)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rest) begin
        if (i_rest) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Decoded from the registered count so the tick never depends on an input.
    assign o_tick = (cnt_q == CntMax);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from a FIFO and sends them as UART frames (start, LSB-first data, stop).
// Optional even parity bit when FIFO_UART_TX_PARITY_EN is defined.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CLK_DIV   = ClkDivDefault,
    parameter int unsigned DIV_BITS  = DivBitsDefault,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic             i_clk,
    input  logic             i_rest,
    input  logic             i_tx_en,
    input  logic             i_empty,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_ren,
    output logic             o_tx,
    output logic             o_busy,
    output logic             o_byte_done
);

    localparam int unsigned   CntW     = $clog2(WIDTH + STOP_BITS + 1);
    localparam logic [CntW-1:0] LastData = CntW'(WIDTH - 1);
    localparam logic [CntW-1:0] LastStop = CntW'(STOP_BITS - 1);

    tx_state_e         state_q, state_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
    logic              tick;
    logic              baud_clr;
`ifdef FIFO_UART_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    // Hold the divider at zero until the frame starts so every bit is a full CLK_DIV long.
    assign baud_clr = (state_q == StIdle) || (state_q == StReq) || (state_q == StLoad);

    uart_baud_tick #(
        .CLK_DIV  (CLK_DIV),
        .DIV_BITS (DIV_BITS)
    ) u_baud (
        .i_clk  (i_clk),
        .i_rest (i_rest),
        .i_clr  (baud_clr),
        .o_tick (tick)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (i_tx_en && !i_empty) state_d = StReq;
            end
            StReq: state_d = StLoad;
            StLoad: begin
                shift_d   = i_data;
                bit_cnt_d = '0;
`ifdef FIFO_UART_TX_PARITY_EN
                parity_d  = ^i_data;
`endif
                state_d   = StStart;
            end
            StStart: begin
                if (tick) state_d = StData;
            end
            StData: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == LastData) begin
                        bit_cnt_d = '0;
`ifdef FIFO_UART_TX_PARITY_EN
                        state_d   = StParity;
`else
                        state_d   = StStop;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            StParity: begin
                if (tick) state_d = StStop;
            end
`endif
            StStop: begin
                if (tick) begin
                    if (bit_cnt_q == LastStop) begin
                        bit_cnt_d = '0;
                        state_d   = StIdle;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rest) begin
        if (i_rest) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            bit_cnt_q <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    // Moore decodes of registered state; reset drives the line high asynchronously.
    always_comb begin
        o_tx = 1'b1;
        unique case (state_q)
            StStart:  o_tx = 1'b0;
            StData:   o_tx = shift_q[0];
`ifdef FIFO_UART_TX_PARITY_EN
            StParity: o_tx = parity_q;
`endif
            default:  o_tx = 1'b1;
        endcase
    end

    assign o_ren       = (state_q == StReq);
    assign o_busy      = (state_q != StIdle);
    assign o_byte_done = (state_q == StStop) && tick && (bit_cnt_q == LastStop);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench for fifo_uart_tx: FIFO model feeds bytes, a line monitor checks each frame.
module tb_fifo_uart_tx;

    localparam int unsigned Width    = 8;
    localparam int unsigned ClkDiv   = 4;
    localparam int unsigned StopBits = 1;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int unsigned ParBits  = 1;
`else
    localparam int unsigned ParBits  = 0;
`endif
    localparam int unsigned NBits    = 1 + Width + ParBits + StopBits;
    localparam int unsigned FrameLen = ClkDiv * NBits;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_en = 1'b0;
    logic       empty = 1'b1;
    logic [7:0] data = 8'h00;
    logic       ren, tx, busy, done;

    fifo_uart_tx #(
        .WIDTH     (Width),
        .CLK_DIV   (ClkDiv),
        .DIV_BITS  (3),
        .STOP_BITS (StopBits)
    ) dut (
        .i_clk       (clk),
        .i_rest      (rst),
        .i_tx_en     (tx_en),
        .i_empty     (empty),
        .i_data      (data),
        .o_ren       (ren),
        .o_tx        (tx),
        .o_busy      (busy),
        .o_byte_done (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] fq[$];
    logic [7:0] exp_q[$];
    int starts[$];
    int ends[$];

    int cyc = 0;
    int frames_started = 0;
    int frames_done = 0;
    int aborted = 0;
    int ren_cnt = 0;
    int done_cnt = 0;
    int bd_stray = 0;
    int last_ren_cyc = -100;
    bit in_frame = 0;

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference line level for bit slot i of a frame carrying byte b.
    function automatic logic exp_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i <= Width) return b[i-1];
        if (ParBits == 1 && i == Width + 1) return ^b;
        return 1'b1;
    endfunction

    task automatic push(input logic [7:0] b);
        fq.push_back(b);
        exp_q.push_back(b);
    endtask

    task automatic wait_frames(input int n, input string name);
        int target;
        int budget;
        target = frames_done + n;
        budget = n * (FrameLen + 20) + 50;
        while (frames_done < target && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        #1;
        check(name, int'(frames_done >= target), 1);
    endtask

    task automatic wait_start(input string name);
        int target;
        int budget;
        target = frames_started + 1;
        budget = 200;
        while (frames_started < target && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        check(name, int'(frames_started >= target), 1);
    endtask

    // FIFO model: data appears the cycle after the read request.
    initial begin
        logic [7:0] pend_d;
        bit pend;
        pend = 0;
        pend_d = 8'h00;
        forever begin
            @(posedge clk);
            #2;
            if (pend) begin
                data = pend_d;
                pend = 0;
            end
            if (!rst && ren) begin
                check("ren_nonempty", int'(fq.size() != 0), 1);
                if (fq.size() != 0) begin
                    pend_d = fq.pop_front();
                    pend = 1;
                end
            end
            empty = (fq.size() == 0);
        end
    end

    // Line monitor: compares every cycle of each frame against the reference waveform.
    initial begin
        logic [7:0] cur;
        logic [7:0] dec;
        int idx;
        int wave_err;
        int bd_err;
        int bi;
        bit prev_ren;
        prev_ren = 0;
        cur = 8'h00;
        dec = 8'h00;
        idx = 0;
        wave_err = 0;
        bd_err = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                if (in_frame) aborted++;
                in_frame = 0;
                prev_ren = 0;
            end else begin
                if (ren) begin
                    ren_cnt++;
                    if (prev_ren) check("ren_single_cycle", 1, 0);
                    last_ren_cyc = cyc;
                end
                prev_ren = ren;
                if (done) done_cnt++;
                if (!in_frame) begin
                    if (done) bd_stray++;
                    if (tx == 1'b0) begin
                        in_frame = 1;
                        idx = 0;
                        wave_err = 0;
                        bd_err = 0;
                        dec = 8'h00;
                        frames_started++;
                        starts.push_back(cyc);
                        check("ren_to_start", cyc - last_ren_cyc, 2);
                        if (exp_q.size() == 0) begin
                            check("frame_expected", 0, 1);
                            cur = 8'h00;
                        end else begin
                            cur = exp_q.pop_front();
                        end
                    end
                end
                if (in_frame) begin
                    bi = idx / ClkDiv;
                    if (tx !== exp_bit(cur, bi) || busy !== 1'b1) wave_err++;
                    if (bi >= 1 && bi <= Width && (idx % ClkDiv) == ClkDiv / 2) dec[bi-1] = tx;
                    if (done !== (idx == FrameLen - 1)) bd_err++;
                    idx++;
                    if (idx == FrameLen) begin
                        check("frame_wave_errs", wave_err, 0);
                        check("frame_byte", int'(dec), int'(cur));
                        check("byte_done_pos_errs", bd_err, 0);
                        ends.push_back(cyc);
                        frames_done++;
                        in_frame = 0;
                    end
                end
            end
        end
    end

    initial begin
        int bad;
        int rc;
        int s;
        int e;
        int budget;

        #1;
        check("rst_tx", int'(tx), 1);
        check("rst_ren", int'(ren), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_byte_done", int'(done), 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        tx_en = 1;
        bad = 0;
        repeat (100) begin
            @(posedge clk);
            #1;
            if (tx !== 1'b1 || ren !== 1'b0 || busy !== 1'b0) bad++;
        end
        check("idle_empty_bad_cycles", bad, 0);

        // Single byte 0xA5.
        push(8'hA5);
        wait_frames(1, "single_frame_seen");
        check("single_ren_count", ren_cnt, 1);
        check("single_done_count", done_cnt, 1);

        // Three preloaded bytes back to back.
        tx_en = 0;
        push(8'h00);
        push(8'hFF);
        push(8'h3C);
        @(posedge clk);
        #1;
        tx_en = 1;
        wait_frames(3, "burst_frames_seen");
        s = starts.size();
        e = ends.size();
        check("burst_gap_1", starts[s-2] - ends[e-3] - 1, 3);
        check("burst_gap_2", starts[s-1] - ends[e-2] - 1, 3);

        // Drop tx_en during data bit 3 of 0x55 with two bytes still queued.
        repeat (10) @(posedge clk);
        #1;
        push(8'h55);
        push(8'h11);
        push(8'h22);
        wait_start("en_drop_start");
        repeat (ClkDiv + 3 * ClkDiv + 1) @(posedge clk);
        #1;
        tx_en = 0;
        rc = ren_cnt;
        wait_frames(1, "en_drop_frame_done");
        repeat (20) @(posedge clk);
        #1;
        check("en_drop_no_ren", ren_cnt, rc);
        check("en_drop_busy", int'(busy), 0);
        check("en_drop_fifo_left", fq.size(), 2);
        tx_en = 1;
        wait_frames(2, "en_resume_frames");

        // Asynchronous reset in the middle of a 0x00 frame (line low during data).
        repeat (5) @(posedge clk);
        #1;
        push(8'h00);
        push(8'h81);
        wait_start("rst_mid_start");
        repeat (6) @(posedge clk);
        #3;
        check("rst_mid_tx_low_before", int'(tx), 0);
        rst = 1;
        #1;
        check("rst_mid_tx_async", int'(tx), 1);
        check("rst_mid_busy", int'(busy), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        wait_frames(1, "rst_recover_frame");
        check("rst_aborted_frames", aborted, 1);

`ifdef FIFO_UART_TX_PARITY_EN
        push(8'h07);
        push(8'h03);
        wait_frames(2, "parity_frames");
`endif

        // Randomized bursts with tx_en toggling.
        for (int k = 0; k < 16; k++) begin
            push(8'($urandom_range(0, 255)));
            if ($urandom_range(0, 3) == 0) begin
                tx_en = 0;
                repeat ($urandom_range(1, 60)) @(posedge clk);
                #1;
                tx_en = 1;
            end
            repeat ($urandom_range(0, 50)) @(posedge clk);
            #1;
        end

        tx_en = 1;
        budget = 20 * (FrameLen + 10) + 100;
        while ((exp_q.size() != 0 || in_frame) && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        #1;
        check("drain_expected_left", exp_q.size(), 0);
        check("drain_fifo_left", fq.size(), 0);
        check("ren_per_frame", ren_cnt, frames_started);
        check("done_per_frame", done_cnt, frames_done);
        check("byte_done_outside_frame", bd_stray, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
